alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external (combinational or fixed-latency) ALU between two
//   requesters. A round-robin arbiter picks one request while idle. The
//   operands are registered onto the ALU ports. After ALU_LAT cycles the
//   ALU result and flags are captured, and they are returned to the
//   requester that was granted.
//
// Handshake rule (both request and response channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high for the same requester bit. valid may not depend on ready. The
//   arbiter raises at most one req_ready bit and at most one rsp_valid bit
//   at a time. rsp_ready on the bit that was not granted is ignored.
//
// Parameters:
//   WIDTH   operand / result width
//   OP_W    opcode width (opcodes 0-9 name ALU functions)
//   ALU_LAT cycles from operand issue to result capture, legal 1-15
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (bit i = req i)
//   req_op/in1/in2        packed per-requester opcode and operands
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_result/flags/err  response payload; flags = {neg, carry, zero}
//   alu_op/in1/in2        registered drive to the shared ALU
//   alu_result/alu_flags  shared ALU outputs (same flag order)
//   busy                  high whenever the FSM is not IDLE
//   dbg_state             current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Build option:
//   ALU_ARBITER_OPCHK_EN  when defined, an accepted opcode above 9 skips the
//                         ALU. It answers one cycle later with rsp_err=1 and a
//                         zero result. When not defined, every opcode is issued
//                         to the ALU and rsp_err is tied low.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*OP_W-1:0]    req_op,
  input  logic [2*WIDTH-1:0]   req_in1,
  input  logic [2*WIDTH-1:0]   req_in2,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [2:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [OP_W-1:0]      alu_op,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [2:0]           alu_flags,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t          state;
  state_t          state_nxt;

  logic            last;      // requester granted by the last completed op
  logic            grant;     // requester owning the op in flight
  logic [3:0]      cnt;       // remaining ALU cycles while in EXEC

  logic            win;       // arbitration winner this cycle
  logic            accept;    // a request is taken on the coming edge
  logic            op_bad;    // accepted opcode is outside 0-9 (checked build)
  logic            cnt_last;  // the coming edge is the capture edge
  logic            rsp_done;  // response taken on the coming edge

  logic [OP_W-1:0]  win_op;
  logic [WIDTH-1:0] win_in1;
  logic [WIDTH-1:0] win_in2;

  // -------------------------------------------------------------------------
  // Round-robin arbitration. When both requesters are valid, the one not
  // granted last time wins. A lone valid requester always wins.
  // -------------------------------------------------------------------------
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && (req_valid != 2'b00);
  assign win_op  = win ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];
  assign win_in1 = win ? req_in1[WIDTH +: WIDTH] : req_in1[0 +: WIDTH];
  assign win_in2 = win ? req_in2[WIDTH +: WIDTH] : req_in2[0 +: WIDTH];

`ifdef ALU_ARBITER_OPCHK_EN
  assign op_bad = (win_op > OP_W'(9));
`else
  assign op_bad = 1'b0;
`endif

  // The counter is loaded with ALU_LAT on acceptance and drops by one each
  // EXEC edge. The edge that sees 1 is the ALU_LAT-th edge after acceptance.
  assign cnt_last = (state == EXEC) && (cnt <= 4'd1);
  assign rsp_done = (state == RESP) && (grant ? rsp_ready[1] : rsp_ready[0]);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready = win ? 2'b10 : 2'b01;
          state_nxt = op_bad ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = grant ? 2'b10 : 2'b01;
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Datapath. The ALU drive registers change only when a legal op is
  // accepted, so they stay stable from one acceptance to the next. The
  // response registers change only on capture (or on the illegal-op bypass),
  // so they hold their values through RESP and afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last       <= 1'b1;
      cnt        <= 4'd0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant <= win;
            if (!op_bad) begin
              alu_op  <= win_op;
              alu_in1 <= win_in1;
              alu_in2 <= win_in2;
              cnt     <= LAT_INIT;
            end else begin
              rsp_result <= '0;
              rsp_flags  <= 3'b000;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt_last) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
          end
        end
        RESP: begin
          if (rsp_done) begin
            last <= grant;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARBITER_OPCHK_EN
  // The error flag is written only at acceptance, so it holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= op_bad;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
